pc_fetch_gen: RTL and testbench
===============================

# pc_fetch_gen

Parametrised fetch-address generator for the fetch stage: holds the architectural fetch PC and issues fetch-group requests to the instruction-side memory interface through a valid/ready handshake. It advances sequentially by 1..FETCH_N instructions and applies exception and branch redirects with fixed priority. A redirect that arrives while a request is waiting for acceptance is buffered, and the stale request is flagged for squash. With the delay-slot option compiled in, it also sequences the MIPS delay-slot fetch.

## Interface
- PC_W, 32, PC width in bits.
- RESET_PC, 32'hBFC0_0000, PC loaded by reset (low PC_W bits used).
- FETCH_N, 2, maximum instructions per fetch group (1 or 2); group byte size is 4*FETCH_N.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fe_stall  in  1  fetch queue full; inhibits raising req_valid.
- exc_valid  in  1  exception/eret redirect request (single-cycle pulse).
- exc_target  in  PC_W  exception/eret target.
- br_valid  in  1  branch/jump redirect request (single-cycle pulse).
- br_target  in  PC_W  branch target.
- br_ds_done  in  1  delay slot of this branch already fetched (used only with PCFG_DELAY_SLOT_EN).
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory side accepts request.
- req_addr  out  PC_W  fetch group address (the current PC).
- req_cnt  out  2  instructions in this group (1 or 2).
- req_adel  out  1  req_addr[1:0] != 0 (address-error tag travels with request).
- fetch_kill  out  1  one-cycle pulse: the request accepted this cycle is stale, and its response must be discarded.
- pc_next_seq  out  PC_W  req_addr + 4*req_cnt, modulo 2^PC_W.

## Operation
- State: pc register; pend_valid/pend_target (buffered redirect); FSM {RUN, DS_WAIT}. DS_WAIT is only reachable with the macro.
- Group size:
  - req_cnt = 1 if FETCH_N==1, or if FETCH_N==2 and pc[2]==1 (realigns to an 8-byte boundary).
  - Otherwise req_cnt = 2.
- req_valid:
  - Rises when !fe_stall and no other blocking condition.
  - Once high, stays high with req_addr, req_cnt and req_adel stable until req_valid&&req_ready.
  - fe_stall does not withdraw a request that is already asserted.
- Accept (req_valid&&req_ready):
  - With no redirect: pc <= pc_next_seq.
  - With pend_valid: pc <= pend_target, pend_valid <= 0, fetch_kill=1 in the same cycle.
- Redirect priority: exc_valid > br_valid > pend_valid > sequential. A new redirect overwrites pend_target.
- Redirect when req_valid==0, or when req_valid==1 and not yet accepted:
  - If req_valid==0: pc <= target next cycle.
  - If a request is pending: buffered in pend_target (the address must stay stable). It is applied at acceptance, and that acceptance pulses fetch_kill.
  - Redirect in the same cycle as acceptance: the accepted request is stale (fetch_kill=1) and pc <= new target.
- Misaligned target: loaded normally, issued with req_adel=1 and req_cnt=1. Sequential advance after it is still +4.
- Arithmetic wraps modulo 2^PC_W, e.g. PC_W=32, pc=32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values (cycle after reset high): pc=RESET_PC, req_valid=0, pend_valid=0, fetch_kill=0, FSM=RUN, req_cnt per the RESET_PC alignment rule, req_adel=0 for an aligned RESET_PC.
- req_valid first asserts one cycle after reset deasserts, if !fe_stall.
- Redirect in cycle t with the interface idle: req_addr=target in cycle t+1.
- Accepted request: next req_addr is available in cycle t+1; a back-to-back request per cycle is possible.
- fetch_kill is combinational with the accepting cycle. It is never asserted when req_valid=0.
- Reset mid-request: the request is dropped and the pending redirect is cleared. The memory side must not count it.

## Configuration
- PCFG_DELAY_SLOT_EN defined:
  - A br_valid with br_ds_done=0 moves RUN->DS_WAIT and latches the target in pend_target without killing anything.
  - The next accepted request is the delay slot. It is forced to req_cnt=1, with fetch_kill=0.
  - Then pc <= pend_target and DS_WAIT->RUN.
  - An exc_valid in DS_WAIT overrides: target replaced, FSM -> RUN, redirect applied immediately.
  - br_ds_done=1 behaves as an immediate redirect.
- PCFG_DELAY_SLOT_EN undefined: br_ds_done is ignored, DS_WAIT does not exist, and every redirect is immediate.

## Test plan
- Reset release, FETCH_N=2, req_ready=1 -> req_addr BFC00000(cnt2), BFC00008(cnt2), BFC00010, one per cycle, no kill.
- pc=BFC00004, FETCH_N=2 -> req_cnt=1, next req_addr=BFC00008, cnt=2.
- req_valid=1 at 80001000 with req_ready=0 for 3 cycles; br_valid to 80002000 in cycle 1 -> req_addr stays 80001000. On acceptance fetch_kill=1, then req_addr=80002000.
- exc_valid(BFC00380) and br_valid(80004000) in the same cycle, interface idle -> next req_addr=BFC00380, and the branch is lost.
- br_target=80000102 -> req_addr=80000102, req_adel=1, req_cnt=1.
- With the macro: br_valid(80003000), br_ds_done=0 at pc=80000010 -> accepts 80000010(cnt1, no kill), then 80003000. Repeating with exc_valid during DS_WAIT -> jumps to the exception target immediately.

Source files
------------

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_gen
//  Description : Fetch-address generator. Holds the fetch PC and issues
//                fetch-group requests over a valid/ready handshake. Handles
//                sequential advance, exception/branch redirects with fixed
//                priority, buffering of redirects behind an outstanding
//                request (with squash of the stale request) and, when the
//                PCFG_DELAY_SLOT_EN macro is defined, MIPS delay-slot
//                sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
   parameter int          PC_W     = 32,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          FETCH_N  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fe_stall,
   input  logic            exc_valid,
   input  logic [PC_W-1:0] exc_target,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            br_ds_done,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [PC_W-1:0] req_addr,
   output logic [1:0]      req_cnt,
   output logic            req_adel,
   output logic            fetch_kill,
   output logic [PC_W-1:0] pc_next_seq
);

   localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);

   // Group size for a PC: a single instruction when groups are one wide,
   // when the PC sits in the upper half of an 8-byte pair (realignment),
   // when it is misaligned, or when the request is a forced delay slot.
   function automatic logic [1:0] grp_cnt(input logic [PC_W-1:0] pc_in,
                                          input logic             force_one);
      if ((FETCH_N == 1) || force_one || pc_in[2] || (pc_in[1:0] != 2'b00))
         grp_cnt = 2'd1;
      else
         grp_cnt = 2'd2;
   endfunction

   // Registered state
   logic [PC_W-1:0] pc_q, pc_d;
   logic            req_valid_q, req_valid_d;
   logic [1:0]      req_cnt_q, req_cnt_d;
   logic            pend_valid_q, pend_valid_d;
   logic [PC_W-1:0] pend_target_q, pend_target_d;

   // Combinational helpers
   logic            w_accept;
   logic            w_hold;
   logic            w_br_now;     // branch that redirects immediately
   logic            w_ds_enter;   // branch that must first fetch its delay slot
   logic            w_in_ds;      // currently waiting for the delay slot
   logic            w_ds_next;    // delay-slot wait in effect next cycle
   logic            w_redir;
   logic [PC_W-1:0] w_redir_tgt;
   logic [PC_W-1:0] w_grp_bytes;
   logic            w_kill;

   assign w_accept    = req_valid_q & req_ready;
   assign w_hold      = req_valid_q & ~req_ready;
   assign w_grp_bytes = {{(PC_W-4){1'b0}}, req_cnt_q, 2'b00};

`ifdef PCFG_DELAY_SLOT_EN
   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_DS_WAIT = 1'b1;

   logic [0:0] state_q, state_d;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // FSM next state: exceptions always return to RUN, a branch without its
   // delay slot parks in DS_WAIT until the delay slot is accepted.
   always_comb begin
      state_d = state_q;
      if (exc_valid)
         state_d = ST_RUN;
      else if (br_valid)
         state_d = br_ds_done ? ST_RUN : ST_DS_WAIT;
      else if ((state_q == ST_DS_WAIT) && w_accept)
         state_d = ST_RUN;
   end

   // FSM output decode feeding the datapath
   always_comb begin
      w_br_now   = br_valid & br_ds_done;
      w_ds_enter = br_valid & ~br_ds_done & ~exc_valid;
      w_in_ds    = (state_q == ST_DS_WAIT);
      w_ds_next  = (state_d == ST_DS_WAIT);
   end
`else
   logic w_unused_ds_done;
   assign w_unused_ds_done = br_ds_done;

   // Without delay-slot support every branch redirects immediately
   always_comb begin
      w_br_now   = br_valid;
      w_ds_enter = 1'b0;
      w_in_ds    = 1'b0;
      w_ds_next  = 1'b0;
   end
`endif

   assign w_redir     = exc_valid | w_br_now;
   assign w_redir_tgt = exc_valid ? exc_target : br_target;

   // Next PC, redirect buffering, squash and request-valid logic
   always_comb begin
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      w_kill        = 1'b0;

      if (w_redir) begin
         if (!req_valid_q || w_accept) begin
            // Idle: jump now. Accepting: the accepted group is stale.
            pc_d         = w_redir_tgt;
            pend_valid_d = 1'b0;
            w_kill       = w_accept;
         end else begin
            // Request still waiting: its address must not move, so park
            // the target until the handshake completes.
            pend_valid_d  = 1'b1;
            pend_target_d = w_redir_tgt;
         end
      end else if (w_ds_enter) begin
         // Branch target waits until the delay slot has been fetched.
         pend_target_d = br_target;
         if (w_accept) begin
            w_kill       = pend_valid_q;
            pc_d         = pend_valid_q ? pend_target_q : pc_next_seq;
            pend_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         if (pend_valid_q || w_in_ds) begin
            // A delay slot is a real instruction; only a buffered redirect
            // makes the accepted group stale.
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            w_kill       = pend_valid_q;
         end else begin
            pc_d = pc_next_seq;
         end
      end

      // An asserted request is held until accepted; fe_stall only gates
      // raising a new one.
      req_valid_d = w_hold ? 1'b1 : ~fe_stall;
      req_cnt_d   = w_hold ? req_cnt_q : grp_cnt(pc_d, w_ds_next);
   end

   // Datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= C_RESET_PC;
         req_valid_q   <= 1'b0;
         req_cnt_q     <= grp_cnt(C_RESET_PC, 1'b0);
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         pc_q          <= pc_d;
         req_valid_q   <= req_valid_d;
         req_cnt_q     <= req_cnt_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign req_valid   = req_valid_q;
   assign req_addr    = pc_q;
   assign req_cnt     = req_cnt_q;
   assign req_adel    = (pc_q[1:0] != 2'b00);
   assign fetch_kill  = w_kill;
   assign pc_next_seq = pc_q + w_grp_bytes;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_gen
//  Description : Self-checking bench for pc_fetch_gen. Expected fetch
//                requests are queued as stimulus is applied and compared at
//                each accepted handshake. Delay-slot scenarios are built when
//                PCFG_DELAY_SLOT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;

   localparam int PC_W = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            fe_stall;
   logic            exc_valid;
   logic [PC_W-1:0] exc_target;
   logic            br_valid;
   logic [PC_W-1:0] br_target;
   logic            br_ds_done;
   logic            req_valid;
   logic            req_ready;
   logic [PC_W-1:0] req_addr;
   logic [1:0]      req_cnt;
   logic            req_adel;
   logic            fetch_kill;
   logic [PC_W-1:0] pc_next_seq;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  cnt;
      logic        adel;
      logic        kill;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pc_fetch_gen #(
      .PC_W     (PC_W),
      .RESET_PC (32'hBFC0_0000),
      .FETCH_N  (2)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .fe_stall    (fe_stall),
      .exc_valid   (exc_valid),
      .exc_target  (exc_target),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .br_ds_done  (br_ds_done),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_cnt     (req_cnt),
      .req_adel    (req_adel),
      .fetch_kill  (fetch_kill),
      .pc_next_seq (pc_next_seq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic expect_req(input logic [31:0] a, input logic [1:0] c,
                             input logic adel, input logic kill);
      exp_t e;
      e.addr = a;
      e.cnt  = c;
      e.adel = adel;
      e.kill = kill;
      q.push_back(e);
   endtask

   // Inputs are set at the falling edge; outputs sampled 1 unit later.
   task automatic tick();
      exp_t e;
      #1;
      if (!reset) begin
         check_eq("kill_without_valid", 64'(fetch_kill & ~req_valid), 64'd0);
         if (req_valid && req_ready) begin
            check_eq("accept_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check_eq("req_addr", 64'(req_addr), 64'(e.addr));
               check_eq("req_cnt", 64'(req_cnt), 64'(e.cnt));
               check_eq("req_adel", 64'(req_adel), 64'(e.adel));
               check_eq("fetch_kill", 64'(fetch_kill), 64'(e.kill));
               check_eq("pc_next_seq", 64'(pc_next_seq),
                        64'(32'(e.addr + 32'(e.cnt) * 32'd4)));
            end
         end
      end
      @(negedge clk);
   endtask

   // Accept requests until the queue empties, stalling on the last one so
   // no extra request is raised afterwards.
   task automatic drain(input int budget);
      int n = 0;
      while (q.size() > 0 && n < budget) begin
         fe_stall  = (q.size() == 1) && req_valid;
         req_ready = 1'b1;
         tick();
         n++;
      end
      check_eq("drain_done", 64'(q.size()), 64'd0);
      q.delete();
      fe_stall  = 1'b1;
      req_ready = 1'b0;
      tick();
      tick();
      check_eq("idle_after_drain", 64'(req_valid), 64'd0);
   endtask

   // Branch redirect with the interface idle; target visible next cycle.
   task automatic redirect_idle(input logic [31:0] t);
      fe_stall   = 1'b1;
      req_ready  = 1'b0;
      br_valid   = 1'b1;
      br_ds_done = 1'b1;
      br_target  = t;
      tick();
      br_valid = 1'b0;
      #1;
      check_eq("redir_addr", 64'(req_addr), 64'(t));
      check_eq("redir_idle", 64'(req_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset      = 1'b1;
      fe_stall   = 1'b0;
      exc_valid  = 1'b0;
      exc_target = '0;
      br_valid   = 1'b0;
      br_target  = '0;
      br_ds_done = 1'b1;
      req_ready  = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_valid", 64'(req_valid), 64'd0);
      check_eq("rst_addr", 64'(req_addr), 64'h0000_0000_BFC0_0000);
      check_eq("rst_cnt", 64'(req_cnt), 64'd2);
      check_eq("rst_adel", 64'(req_adel), 64'd0);
      check_eq("rst_kill", 64'(fetch_kill), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Sequential fetch after reset release
      expect_req(32'hBFC0_0000, 2'd2, 1'b0, 1'b0);
      expect_req(32'hBFC0_0008, 2'd2, 1'b0, 1'b0);
      expect_req(32'hBFC0_0010, 2'd2, 1'b0, 1'b0);
      drain(20);

      // Realignment from the upper half of a pair
      redirect_idle(32'hBFC0_0004);
      expect_req(32'hBFC0_0004, 2'd1, 1'b0, 1'b0);
      expect_req(32'hBFC0_0008, 2'd2, 1'b0, 1'b0);
      drain(20);

      // Redirect buffered behind a request that waits for acceptance
      redirect_idle(32'h8000_1000);
      fe_stall = 1'b0;
      tick();
      expect_req(32'h8000_1000, 2'd2, 1'b0, 1'b1);
      expect_req(32'h8000_2000, 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fe_stall  = 1'b1;
         br_valid  = (i == 0);
         br_target = 32'h8000_2000;
         tick();
         br_valid = 1'b0;
         #1;
         check_eq("hold_valid", 64'(req_valid), 64'd1);
         check_eq("hold_addr", 64'(req_addr), 64'h0000_0000_8000_1000);
      end
      fe_stall  = 1'b0;
      req_ready = 1'b1;
      tick();
      drain(20);

      // Exception beats a simultaneous branch
      fe_stall   = 1'b1;
      exc_valid  = 1'b1;
      exc_target = 32'hBFC0_0380;
      br_valid   = 1'b1;
      br_target  = 32'h8000_4000;
      tick();
      exc_valid = 1'b0;
      br_valid  = 1'b0;
      expect_req(32'hBFC0_0380, 2'd2, 1'b0, 1'b0);
      expect_req(32'hBFC0_0388, 2'd2, 1'b0, 1'b0);
      drain(20);

      // Misaligned target
      redirect_idle(32'h8000_0102);
      expect_req(32'h8000_0102, 2'd1, 1'b1, 1'b0);
      expect_req(32'h8000_0106, 2'd1, 1'b1, 1'b0);
      drain(20);

      // Redirect in the same cycle as acceptance
      redirect_idle(32'h8000_5000);
      fe_stall = 1'b0;
      tick();
      expect_req(32'h8000_5000, 2'd2, 1'b0, 1'b1);
      expect_req(32'h8000_6000, 2'd2, 1'b0, 1'b0);
      req_ready = 1'b1;
      br_valid  = 1'b1;
      br_target = 32'h8000_6000;
      tick();
      br_valid = 1'b0;
      drain(20);

      // Address wrap
      redirect_idle(32'hFFFF_FFFC);
      expect_req(32'hFFFF_FFFC, 2'd1, 1'b0, 1'b0);
      expect_req(32'h0000_0000, 2'd2, 1'b0, 1'b0);
      drain(20);

      // Reset while a request and a buffered redirect are outstanding
      redirect_idle(32'h8000_7000);
      fe_stall = 1'b0;
      tick();
      br_valid  = 1'b1;
      br_target = 32'h8000_8000;
      tick();
      br_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(req_valid), 64'd0);
      check_eq("midrst_addr", 64'(req_addr), 64'h0000_0000_BFC0_0000);
      expect_req(32'hBFC0_0000, 2'd2, 1'b0, 1'b0);
      drain(20);

`ifdef PCFG_DELAY_SLOT_EN
      // Branch whose delay slot is still to be fetched
      redirect_idle(32'h8000_0010);
      br_valid   = 1'b1;
      br_ds_done = 1'b0;
      br_target  = 32'h8000_3000;
      tick();
      br_valid   = 1'b0;
      br_ds_done = 1'b1;
      expect_req(32'h8000_0010, 2'd1, 1'b0, 1'b0);
      expect_req(32'h8000_3000, 2'd2, 1'b0, 1'b0);
      drain(20);

      // Exception during the delay-slot wait takes over immediately
      redirect_idle(32'h8000_0020);
      br_valid   = 1'b1;
      br_ds_done = 1'b0;
      br_target  = 32'h8000_3000;
      tick();
      br_valid   = 1'b0;
      br_ds_done = 1'b1;
      exc_valid  = 1'b1;
      exc_target = 32'hBFC0_0380;
      tick();
      exc_valid = 1'b0;
      #1;
      check_eq("ds_exc_addr", 64'(req_addr), 64'h0000_0000_BFC0_0380);
      expect_req(32'hBFC0_0380, 2'd2, 1'b0, 1'b0);
      drain(20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
